// File: rtl/morse_letter_sequencer_if.sv
// morse_letter_sequencer_if: letter request in (start/symbol/size), Morse LED and status out (led/busy/done)
interface morse_letter_sequencer_if;
  logic       start;
  logic [3:0] symbol;
  logic [2:0] size;
  logic       led;
  logic       busy;
  logic       done;
  modport master (output start, symbol, size, input led, busy, done);
  modport slave (input start, symbol, size, output led, busy, done);
endinterface

// File: rtl/morse_letter_sequencer.sv
// morse_letter_sequencer: plays one left-justified Morse letter on led; ports clk, reset (sync, active-low), bus (start/symbol/size in, led/busy/done out)
module morse_letter_sequencer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int DOT_UNITS  = 1,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  morse_letter_sequencer_if.slave   bus
);
  localparam int TW   = $clog2(TICK_DIV);
  localparam int MAXU = (DASH_UNITS > DOT_UNITS) ? ((DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS)
                                                 : ((DOT_UNITS > GAP_UNITS) ? DOT_UNITS : GAP_UNITS);
  localparam int UW   = $clog2(MAXU + 1);
  typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [3:0]      shift_q, shift_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            led_q, busy_q, done_q;
  logic            tick_end, on_end, gap_end;
  assign tick_end = tick_q == TW'(TICK_DIV - 1);
  // element length follows the bit currently at the top of the shift register
  assign on_end   = tick_end && unit_q == (shift_q[3] ? UW'(DASH_UNITS - 1) : UW'(DOT_UNITS - 1));
  assign gap_end  = tick_end && unit_q == UW'(GAP_UNITS - 1);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tick_d  = tick_end ? '0 : tick_q + TW'(1);
    unit_d  = tick_end ? unit_q + UW'(1) : unit_q;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        unit_d = '0;
        if (bus.start) begin
          shift_d = bus.symbol;
          cnt_d   = bus.size > 3'd4 ? 3'd4 : bus.size;
          state_d = bus.size == 3'd0 ? DONE : ON;
        end
      end
      ON: if (on_end) begin
        tick_d  = '0;
        unit_d  = '0;
        cnt_d   = cnt_q - 3'd1;
        shift_d = {shift_q[2:0], 1'b0};
        state_d = cnt_q == 3'd1 ? DONE : GAP;
      end
      GAP: if (gap_end) begin
        tick_d  = '0;
        unit_d  = '0;
        state_d = ON;
      end
      default: begin
        tick_d  = '0;
        unit_d  = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      unit_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      led_q   <= state_d == ON;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_morse_letter_sequencer.sv
// tb_morse_letter_sequencer: scoreboarded directed test of the Morse letter sequencer at TICK_DIV=4
module tb_morse_letter_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] sb[$];
  int checks = 0;
  int fails = 0;
  morse_letter_sequencer_if bus ();
  always #5 clk = ~clk;
  morse_letter_sequencer #(.TICK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  task automatic check(input string tag);
    logic [2:0] exp, obs;
    exp = sb.pop_front();
    obs = {bus.led, bus.busy, bus.done};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s led/busy/done obs=%b exp=%b", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [3:0] sym, input int sz);
    int n;
    logic [3:0] s;
    n = sz > 4 ? 4 : sz;
    s = sym;
    for (int e = 0; e < n; e++) begin
      repeat (s[3] ? 12 : 4) sb.push_back(3'b110);
      if (e < n - 1) repeat (4) sb.push_back(3'b010);
      s = {s[2:0], 1'b0};
    end
    sb.push_back(3'b011);
    sb.push_back(3'b000);
  endfunction
  task automatic play(input string tag, input logic [3:0] sym, input int sz, input int inj, input int rst_at);
    int n;
    model(sym, sz);
    if (rst_at > 0) begin
      while (sb.size() > rst_at) void'(sb.pop_back());
      repeat (3) sb.push_back(3'b000);
    end
    bus.start  = 1'b1;
    bus.symbol = sym;
    bus.size   = sz[2:0];
    n = sb.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 2) begin
        bus.symbol = ~sym;
        bus.size   = 3'd4;
      end
      if (c == inj) begin
        bus.start  = 1'b1;
        bus.symbol = 4'b1111;
        bus.size   = 3'd4;
      end
      if (c == inj + 1) bus.start = 1'b0;
      if (c == rst_at) reset = 1'b0;
      if (c == rst_at + 1) reset = 1'b1;
      check($sformatf("%s c%0d", tag, c));
    end
  endtask
  initial begin
    bus.start  = 1'b1;
    bus.symbol = 4'b0100;
    bus.size   = 3'd2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sb.push_back(3'b000);
      check($sformatf("reset c%0d", i));
    end
    reset = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    sb.push_back(3'b000);
    check("reset_release");
    play("A", 4'b0100, 2, 0, 0);
    play("O", 4'b1110, 3, 0, 0);
    play("T", 4'b1000, 1, 0, 0);
    play("A_busy_start", 4'b0100, 2, 6, 0);
    play("size0", 4'b1010, 0, 0, 0);
    play("size7", 4'b0000, 7, 0, 0);
    play("A_reset", 4'b0100, 2, 0, 10);
    play("A_after_reset", 4'b0100, 2, 0, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
